// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared types, width helper and parameter limits
// for the sequenced reset generator.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int NUM_OUT_MIN     = 1;
  localparam int NUM_OUT_MAX     = 16;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int MIN_ASSERT_MIN  = 1;
  localparam int STAGE_DELAY_MIN = 1;

  function automatic int cnt_width(
    input int min_assert,
    input int stage_delay
  );
    int m;
    m = (min_assert > stage_delay) ? min_assert : stage_delay;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/resn_sync_chain.sv
// resn_sync_chain: async-assert, sync-deassert reset synchroniser
// of STAGES flops.
module resn_sync_chain #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic resn_in,
  output logic resn_sync
);

  (* ASYNC_REG = "TRUE", IOB = "FALSE" *)
  logic [STAGES-1:0] q;

  always_ff @(posedge clk or negedge resn_in) begin
    if (!resn_in) begin
      q <= '0;
    end else begin
      q <= {q[STAGES-2:0], 1'b1};
    end
  end

  assign resn_sync = q[STAGES-1];

endmodule

// File: rtl/reset_seq.sv
// reset_seq: releases NUM_OUT active-low resets one by one.
// Macro RESET_SEQ_SW_REQ_EN enables the sw_rst_req restart input.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int NUM_OUT     = 4,
  parameter int SYNC_STAGES = 3,
  parameter int MIN_ASSERT  = 16,
  parameter int STAGE_DELAY = 8,
  parameter int REVERSE     = 0
) (
  input  logic               clk,
  input  logic               resn_in,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] resn_out,
  output logic               seq_done
);

  localparam int CW = cnt_width(MIN_ASSERT, STAGE_DELAY);
  localparam logic [CW-1:0] MIN_LAST = CW'(MIN_ASSERT - 1);
  localparam logic [CW-1:0] SD_LAST  = CW'(STAGE_DELAY - 1);

  if (NUM_OUT < NUM_OUT_MIN || NUM_OUT > NUM_OUT_MAX) begin : g_bad_num
    $error("reset_seq: NUM_OUT out of range");
  end
  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
    $error("reset_seq: SYNC_STAGES too small");
  end
  if (MIN_ASSERT < MIN_ASSERT_MIN) begin : g_bad_min
    $error("reset_seq: MIN_ASSERT too small");
  end
  if (STAGE_DELAY < STAGE_DELAY_MIN) begin : g_bad_sd
    $error("reset_seq: STAGE_DELAY too small");
  end
  if (REVERSE != 0 && REVERSE != 1) begin : g_bad_rev
    $error("reset_seq: REVERSE must be 0 or 1");
  end

  logic               resn_sync;
  logic               sw_req;
  state_e             state;
  logic [CW-1:0]      cnt;
  logic [NUM_OUT-1:0] rel;

`ifdef RESET_SEQ_SW_REQ_EN
  assign sw_req = sw_rst_req;
`else
  logic sw_rst_req_unused;
  assign sw_req            = 1'b0;
  assign sw_rst_req_unused = sw_rst_req;
`endif

  resn_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .resn_in   (resn_in),
    .resn_sync (resn_sync)
  );

  // rel is kept in release-slot order; slot 0 fills first
  always_ff @(posedge clk or negedge resn_in) begin
    if (!resn_in) begin
      state    <= HOLD;
      cnt      <= '0;
      rel      <= '0;
      seq_done <= 1'b0;
    end else if (sw_req) begin
      state    <= HOLD;
      cnt      <= '0;
      rel      <= '0;
      seq_done <= 1'b0;
    end else begin
      unique case (state)
        HOLD: begin
          if (resn_sync) begin
            if (cnt == MIN_LAST) begin
              rel   <= NUM_OUT'(1);
              cnt   <= '0;
              state <= RELEASE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RELEASE: begin
          if (&rel) begin
            state    <= DONE;
            seq_done <= 1'b1;
          end else if (cnt == SD_LAST) begin
            rel <= (rel << 1) | NUM_OUT'(1);
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          seq_done <= 1'b1;
        end
        default: begin
          state <= HOLD;
        end
      endcase
    end
  end

  // pure wiring: each output bit is a flop output
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_map
    if (REVERSE != 0) begin : g_rev
      assign resn_out[NUM_OUT-1-k] = rel[k];
    end else begin : g_fwd
      assign resn_out[k] = rel[k];
    end
  end

endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: scoreboard bench for reset_seq, three instances
// (forward, reversed, single-output).
module tb_reset_seq;

  logic       clk = 1'b0;
  logic       resn_in = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic [2:0] r0;
  logic [2:0] r1;
  logic [0:0] r2;
  logic       d0;
  logic       d1;
  logic       d2;

  int checks   = 0;
  int failures = 0;
  int ep       = 0;
  int t_cur    = 2;

  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  reset_seq #(
    .NUM_OUT(3), .SYNC_STAGES(3), .MIN_ASSERT(4),
    .STAGE_DELAY(2), .REVERSE(0)
  ) dut0 (
    .clk(clk), .resn_in(resn_in), .sw_rst_req(sw_rst_req),
    .resn_out(r0), .seq_done(d0)
  );

  reset_seq #(
    .NUM_OUT(3), .SYNC_STAGES(3), .MIN_ASSERT(4),
    .STAGE_DELAY(2), .REVERSE(1)
  ) dut1 (
    .clk(clk), .resn_in(resn_in), .sw_rst_req(sw_rst_req),
    .resn_out(r1), .seq_done(d1)
  );

  reset_seq #(
    .NUM_OUT(1), .SYNC_STAGES(3), .MIN_ASSERT(4),
    .STAGE_DELAY(2), .REVERSE(0)
  ) dut2 (
    .clk(clk), .resn_in(resn_in), .sw_rst_req(sw_rst_req),
    .resn_out(r2), .seq_done(d2)
  );

  // expected {r0, r1, r2, d0, d1, d2} after edge n, sequence start t
  function automatic logic [9:0] model(input int n, input int t);
    logic [2:0] f;
    logic [2:0] rv;
    logic       one;
    logic       df;
    logic       d1f;
    int         k;
    k = (n < t + 4) ? 0 : (n - t - 4) / 2 + 1;
    if (k > 3) k = 3;
    f   = 3'((1 << k) - 1);
    rv  = {f[0], f[1], f[2]};
    one = (n >= t + 4);
    df  = (n >= t + 4 + 2 * 2 + 1);
    d1f = (n >= t + 5);
    return {f, rv, one, df, df, d1f};
  endfunction

  task automatic test_reset;
    logic [9:0] got;
    #2 resn_in = 1'b0;
    #1;
    got = {r0, r1, r2, d0, d1, d2};
    checks++;
    if (got !== 10'b0) begin
      failures++;
      $display("FAIL reset_async got=%b exp=%b", got, 10'b0);
    end
    repeat (5) begin
      @(posedge clk);
      #1;
      got = {r0, r1, r2, d0, d1, d2};
      checks++;
      if (got !== 10'b0) begin
        failures++;
        $display("FAIL reset_hold got=%b exp=%b", got, 10'b0);
      end
    end
    resn_in = 1'b1;
    ep      = 0;
    t_cur   = 2;
  endtask

  task automatic test_powerup;
    logic [9:0] got;
    logic [9:0] expv;
    while (ep <= 14) begin
      exp_q.push_back(model(ep, t_cur));
      @(posedge clk);
      #1;
      got  = {r0, r1, r2, d0, d1, d2};
      expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL powerup e%0d got=%b exp=%b", ep, got, expv);
      end
      ep++;
    end
  endtask

  task automatic test_async_mid;
    logic [9:0] got;
    logic [9:0] expv;
    resn_in = 1'b0;
    #1;
    got = {r0, r1, r2, d0, d1, d2};
    checks++;
    if (got !== 10'b0) begin
      failures++;
      $display("FAIL async_done got=%b exp=%b", got, 10'b0);
    end
    @(posedge clk);
    #1;
    resn_in = 1'b1;
    ep      = 0;
    t_cur   = 2;
    while (ep <= 7) begin
      exp_q.push_back(model(ep, t_cur));
      @(posedge clk);
      #1;
      got  = {r0, r1, r2, d0, d1, d2};
      expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL async_pre e%0d got=%b exp=%b", ep, got, expv);
      end
      ep++;
    end
    resn_in = 1'b0;
    #1;
    got = {r0, r1, r2, d0, d1, d2};
    checks++;
    if (got !== 10'b0) begin
      failures++;
      $display("FAIL async_mid got=%b exp=%b", got, 10'b0);
    end
    @(posedge clk);
    #1;
    got = {r0, r1, r2, d0, d1, d2};
    checks++;
    if (got !== 10'b0) begin
      failures++;
      $display("FAIL async_low got=%b exp=%b", got, 10'b0);
    end
    resn_in = 1'b1;
    ep      = 0;
    while (ep <= 14) begin
      exp_q.push_back(model(ep, t_cur));
      @(posedge clk);
      #1;
      got  = {r0, r1, r2, d0, d1, d2};
      expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL async_replay e%0d got=%b exp=%b", ep, got, expv);
      end
      ep++;
    end
  endtask

  task automatic test_sw_req;
    logic [9:0] got;
    logic [9:0] expv;
    while (ep <= 32) begin
      sw_rst_req = (ep == 20);
`ifdef RESET_SEQ_SW_REQ_EN
      if (sw_rst_req) t_cur = ep;
`endif
      exp_q.push_back(model(ep, t_cur));
      @(posedge clk);
      #1;
      got  = {r0, r1, r2, d0, d1, d2};
      expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL sw_req e%0d got=%b exp=%b", ep, got, expv);
      end
      ep++;
    end
    sw_rst_req = 1'b0;
  endtask

  task automatic test_held_priority;
    logic [9:0] got;
    logic [9:0] expv;
    resn_in = 1'b0;
    #1;
    got = {r0, r1, r2, d0, d1, d2};
    checks++;
    if (got !== 10'b0) begin
      failures++;
      $display("FAIL held_rst got=%b exp=%b", got, 10'b0);
    end
    @(posedge clk);
    #1;
    resn_in = 1'b1;
    ep      = 0;
    t_cur   = 2;
    while (ep <= 45) begin
      sw_rst_req = (ep >= 20 && ep <= 25) || (ep == 31);
`ifdef RESET_SEQ_SW_REQ_EN
      if (sw_rst_req) t_cur = ep;
`endif
      exp_q.push_back(model(ep, t_cur));
      @(posedge clk);
      #1;
      got  = {r0, r1, r2, d0, d1, d2};
      expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL held_prio e%0d got=%b exp=%b", ep, got, expv);
      end
      ep++;
    end
    sw_rst_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_async_mid();
    test_sw_req();
    test_held_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
